lfsr_rand_range: RTL



---
 rtl/lfsr_rand_range_pkg.sv | 41 ++++
 rtl/lfsr_rand_range_if.sv | 12 +
 rtl/lfsr_rand_range_core.sv | 34 +++
 rtl/lfsr_rand_range.sv | 81 ++++++++
 4 files changed

// File: rtl/lfsr_rand_range_pkg.sv
// lfsr_rand_pkg: FSM encoding, XNOR tap masks and lock-up constant for lfsr_rand_range
package lfsr_rand_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  localparam logic [31:0] LOCKUP = '1;
  // bit t-1 is set for every tap t of the maximal-length XNOR LFSR of width n
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/lfsr_rand_range_if.sv
// lfsr_rand_range_if: request/response handshake between a requester and lfsr_rand_range
interface lfsr_rand_range_if #(parameter int OUT_BITS = 8) ();
  logic                Req_Valid;
  logic                Req_Ready;
  logic [OUT_BITS-1:0] Range;
  logic                Rand_Valid;
  logic                Rand_Ready;
  logic [OUT_BITS-1:0] Rand_Data;
  logic                Rand_Fallback;
  modport master (output Req_Valid, Range, Rand_Ready, input Req_Ready, Rand_Valid, Rand_Data, Rand_Fallback);
  modport slave (input Req_Valid, Range, Rand_Ready, output Req_Ready, Rand_Valid, Rand_Data, Rand_Fallback);
endinterface

// File: rtl/lfsr_rand_range_core.sv
// lfsr_core: XNOR Fibonacci LFSR with lock-up-safe seeding and full-period done pulse
module lfsr_core #(
  parameter int NUM_BITS = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Step,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);
  import lfsr_rand_pkg::*;
  localparam logic [31:0] TAPS = tap_mask(NUM_BITS);
  logic [NUM_BITS-1:0] r_Seed, w_Next, w_Load;
  always_comb begin
    w_Next = {o_LFSR_Data[NUM_BITS-2:0], ~^(o_LFSR_Data & TAPS[NUM_BITS-1:0])};
    w_Load = (i_Seed_Data == LOCKUP[NUM_BITS-1:0]) ? '0 : i_Seed_Data;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LFSR_Data <= '0;
      r_Seed      <= '0;
      o_LFSR_Done <= 1'b0;
    end else if (i_Seed_DV) begin
      o_LFSR_Data <= w_Load;
      r_Seed      <= w_Load;
      o_LFSR_Done <= 1'b0;
    end else begin
      o_LFSR_Done <= i_Step && (w_Next == r_Seed);
      if (i_Step) o_LFSR_Data <= w_Next;
    end
  end
endmodule

// File: rtl/lfsr_rand_range.sv
// lfsr_rand_range: bounded LFSR random source with rejection sampling; RNG_STATS_EN builds the reject counter
module lfsr_rand_range #(
  parameter int NUM_BITS  = 16,
  parameter int OUT_BITS  = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  lfsr_rand_range_if.slave    bus,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic [15:0]         o_Reject_Cnt
);
  import lfsr_rand_pkg::*;
  state_t              r_State;
  logic [7:0]          r_Tries;
  logic [OUT_BITS-1:0] r_Range, w_Cand, w_Mask;
  logic                w_Accept;
  lfsr_core #(.NUM_BITS(NUM_BITS)) u_core (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Step      (r_State == DRAW || i_Enable),
    .i_Seed_DV   (i_Seed_DV),
    .i_Seed_Data (i_Seed_Data),
    .o_LFSR_Data (o_LFSR_Data),
    .o_LFSR_Done (o_LFSR_Done)
  );
  // fallback mask keeps only the bits below the range's MSB, so the result stays < range
  always_comb begin
    w_Cand   = o_LFSR_Data[OUT_BITS-1:0];
    w_Accept = (r_Range == '0) || (w_Cand < r_Range);
    w_Mask   = '0;
    for (int i = 0; i < OUT_BITS; i++) w_Mask[i] = |(r_Range >> (i + 1));
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State           <= IDLE;
      r_Tries           <= '0;
      r_Range           <= '0;
      bus.Req_Ready     <= 1'b1;
      bus.Rand_Valid    <= 1'b0;
      bus.Rand_Data     <= '0;
      bus.Rand_Fallback <= 1'b0;
    end else begin
      case (r_State)
        IDLE: if (bus.Req_Valid) begin
          r_Range       <= bus.Range;
          r_Tries       <= '0;
          bus.Req_Ready <= 1'b0;
          r_State       <= DRAW;
        end
        DRAW: begin
          r_Tries <= w_Accept ? r_Tries : r_Tries + 8'd1;
          if (w_Accept || r_Tries == 8'(MAX_TRIES - 1)) begin
            bus.Rand_Data     <= w_Accept ? w_Cand : (w_Cand & w_Mask);
            bus.Rand_Fallback <= !w_Accept;
            bus.Rand_Valid    <= 1'b1;
            r_State           <= HOLD;
          end
        end
        HOLD: if (bus.Rand_Ready) begin
          bus.Rand_Valid <= 1'b0;
          bus.Req_Ready  <= 1'b1;
          r_State        <= IDLE;
        end
        default: r_State <= IDLE;
      endcase
    end
  end
`ifdef RNG_STATS_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) o_Reject_Cnt <= '0;
    else if (r_State == DRAW && !w_Accept && o_Reject_Cnt != 16'hFFFF) o_Reject_Cnt <= o_Reject_Cnt + 16'd1;
  end
`else
  assign o_Reject_Cnt = '0;
`endif
endmodule
